// File: rtl/io_port.sv
// io_port: CHANNELS synchronised, debounced, change-flagged input ports plus bus-loaded output latches.
// Optional IO_PORT_BITOP_EN: in[15:14] selects load/set/clear/toggle on writes (requires WIDTH <= 14).
module io_port #(
  parameter int          CHANNELS  = 2,
  parameter int          SEL_BITS  = 1,
  parameter int          WIDTH     = 8,
  parameter int          DEBOUNCE  = 4,
  parameter logic [7:0]  RESET_OUT = 8'h55
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SEL_BITS-1:0]       sel,
  input  logic                      in_en,
  input  logic [15:0]               in,
  input  logic                      out_en,
  output logic [15:0]               out,
  input  logic [CHANNELS*WIDTH-1:0] pins_in,
  output logic [CHANNELS*WIDTH-1:0] pins_out,
  output logic                      irq
);

  localparam int                CW       = $clog2(DEBOUNCE);
  localparam logic [CW-1:0]     CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [WIDTH-1:0]  RST_W    = WIDTH'(RESET_OUT);

  logic [CHANNELS*WIDTH-1:0]          sync1, sync2;
  logic [CHANNELS-1:0][WIDTH-1:0]     stable;
  logic [CHANNELS-1:0]                flag;
  logic                               unused_bus;

  assign unused_bus = ^in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pins_in;
      sync2 <= sync1;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [WIDTH-1:0] s2, st_q, pout_q, wr_val;
    logic [CW-1:0]    cnt_q;
    logic             flag_q, accept, rd_hit, wr_hit;

    assign s2     = sync2[k*WIDTH +: WIDTH];
    assign accept = (s2 != st_q) && (cnt_q == CNT_LAST);
    assign rd_hit = out_en && (32'(sel) == k);
    assign wr_hit = in_en && (32'(sel) == k);

    always_comb begin
      wr_val = in[WIDTH-1:0];
`ifdef IO_PORT_BITOP_EN
      case (in[15:14])
        2'b01:   wr_val = pout_q | in[WIDTH-1:0];
        2'b10:   wr_val = pout_q & ~in[WIDTH-1:0];
        2'b11:   wr_val = pout_q ^ in[WIDTH-1:0];
        default: wr_val = in[WIDTH-1:0];
      endcase
`endif
    end

    // Any return of sync2 to the accepted value restarts the stability count.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q  <= '0;
        cnt_q <= '0;
      end else if (s2 == st_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        st_q  <= s2;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    // A new acceptance outranks a read-clear on the same edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)         flag_q <= 1'b0;
      else if (accept) flag_q <= 1'b1;
      else if (rd_hit) flag_q <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)         pout_q <= RST_W;
      else if (wr_hit) pout_q <= wr_val;
    end

    assign stable[k]                  = st_q;
    assign flag[k]                    = flag_q;
    assign pins_out[k*WIDTH +: WIDTH] = pout_q;
  end

  always_comb begin
    out = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (out_en && (32'(sel) == k)) out[WIDTH-1:0] = stable[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= |flag;
  end

endmodule

// File: tb/tb_io_port.sv
// Self-checking bench for io_port: directed scenarios plus randomized pins/bus traffic
// compared every cycle against a delay-line/run-length reference model.
module tb_io_port;
  localparam int CH = 2;
  localparam int SB = 2;
  localparam int W  = 8;
  localparam int D  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [SB-1:0]     sel;
  logic              in_en, out_en;
  logic [15:0]       bus_in, bus_out;
  logic [CH*W-1:0]   pins_in, pins_out;
  logic              irq;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [7:0] m_sy1 [CH];
  logic [7:0] m_sy2 [CH];
  logic [7:0] m_st  [CH];
  logic [7:0] m_pout[CH];
  int         m_run [CH];
  bit         m_flag[CH];
  bit         m_irq;

  io_port #(.CHANNELS(CH), .SEL_BITS(SB), .WIDTH(W), .DEBOUNCE(D), .RESET_OUT(8'h55)) dut (
    .clk(clk), .rst(rst), .sel(sel), .in_en(in_en), .in(bus_in), .out_en(out_en),
    .out(bus_out), .pins_in(pins_in), .pins_out(pins_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_sy1[c] = '0; m_sy2[c] = '0; m_st[c] = '0; m_run[c] = 0;
      m_flag[c] = 1'b0; m_pout[c] = 8'h55;
    end
    m_irq = 1'b0;
  endfunction

  function automatic logic [15:0] model_out(input logic [SB-1:0] s, input logic re);
    if (re && int'(s) < CH) return {8'h00, m_st[s]};
    return 16'h0000;
  endfunction

  function automatic logic [7:0] write_result(input logic [7:0] cur, input logic [15:0] d);
`ifdef IO_PORT_BITOP_EN
    case (d[15:14])
      2'b01:   return cur | d[7:0];
      2'b10:   return cur & ~d[7:0];
      2'b11:   return cur ^ d[7:0];
      default: return d[7:0];
    endcase
`else
    return d[7:0];
`endif
  endfunction

  // One clock edge: a value is accepted once sync2 has differed from stable for D edges in a row.
  function automatic void model_step(input logic [15:0] p, input logic [SB-1:0] s,
                                     input logic we, input logic re, input logic [15:0] d);
    bit any_flag = 1'b0;
    for (int c = 0; c < CH; c++) any_flag |= m_flag[c];
    for (int c = 0; c < CH; c++) begin
      bit acc = 1'b0;
      if (m_sy2[c] == m_st[c]) m_run[c] = 0;
      else begin
        m_run[c]++;
        if (m_run[c] == D) begin
          m_st[c] = m_sy2[c]; m_run[c] = 0; acc = 1'b1;
        end
      end
      if (acc) m_flag[c] = 1'b1;
      else if (re && int'(s) == c) m_flag[c] = 1'b0;
      m_sy2[c] = m_sy1[c];
      m_sy1[c] = p[c*8 +: 8];
    end
    if (we && int'(s) < CH) m_pout[s] = write_result(m_pout[s], d);
    m_irq = any_flag;
  endfunction

  // Called just after a negedge; drives inputs, checks out, advances one edge, checks registers.
  task automatic cycle(input logic [15:0] p, input logic [SB-1:0] s, input logic we,
                       input logic re, input logic [15:0] d);
    pins_in = p; sel = s; in_en = we; out_en = re; bus_in = d;
    #1 check("out", {16'h0, bus_out}, {16'h0, model_out(s, re)});
    model_step(p, s, we, re, d);
    @(posedge clk);
    @(negedge clk);
    check("pins_out", {16'h0, pins_out}, {16'h0, m_pout[1], m_pout[0]});
    check("irq", {31'h0, irq}, {31'h0, m_irq});
  endtask

  task automatic peek(input logic [SB-1:0] s, input logic [15:0] exp);
    sel = s; out_en = 1'b1;
    #1 check("peek", {16'h0, bus_out}, {16'h0, exp});
    out_en = 1'b0;
  endtask

  task automatic do_reset();
    in_en = 1'b0; out_en = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_pins_out", {16'h0, pins_out}, 32'h5555);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_out", {16'h0, bus_out}, 32'h0);
    model_reset();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] hold_val[CH];
    int         hold_cnt[CH];
    logic [15:0] p;

    rst = 1'b1; sel = '0; in_en = 1'b0; out_en = 1'b0; bus_in = '0; pins_in = '0;
    model_reset();
    @(negedge clk);
    check("init_pins_out", {16'h0, pins_out}, 32'h5555);
    check("init_irq", {31'h0, irq}, 32'h0);
    check("init_out", {16'h0, bus_out}, 32'h0);
    rst = 1'b0;

    // clean step on ch0: accepted on edge 6, irq on edge 7
    for (int i = 1; i <= 5; i++) cycle(16'h00A5, 0, 1'b0, 1'b0, 16'h0);
    peek(0, 16'h0000);
    cycle(16'h00A5, 0, 1'b0, 1'b0, 16'h0);
    peek(0, 16'h00A5);
    check("clean_irq_e6", {31'h0, irq}, 32'h0);
    cycle(16'h00A5, 0, 1'b0, 1'b0, 16'h0);
    check("clean_irq_e7", {31'h0, irq}, 32'h1);
    cycle(16'h00A5, 0, 1'b0, 1'b1, 16'h0);
    check("clean_irq_rd", {31'h0, irq}, 32'h1);
    cycle(16'h00A5, 0, 1'b0, 1'b0, 16'h0);
    check("clean_irq_clr", {31'h0, irq}, 32'h0);

    // glitch on ch1 shorter than DEBOUNCE is rejected
    for (int i = 0; i < 3; i++) cycle(16'h3CA5, 0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 6; i++) cycle(16'h00A5, 0, 1'b0, 1'b0, 16'h0);
    peek(1, 16'h0000);
    check("glitch_irq", {31'h0, irq}, 32'h0);
    // a pulse stable for DEBOUNCE samples is accepted
    for (int i = 0; i < 4; i++) cycle(16'h3CA5, 0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 2; i++) cycle(16'h00A5, 0, 1'b0, 1'b0, 16'h0);
    peek(1, 16'h003C);
    cycle(16'h00A5, 0, 1'b0, 1'b0, 16'h0);
    check("pulse_irq", {31'h0, irq}, 32'h1);
    for (int i = 0; i < 8; i++) cycle(16'h00A5, 0, 1'b0, 1'b0, 16'h0);
    cycle(16'h00A5, 1, 1'b0, 1'b1, 16'h0);
    cycle(16'h00A5, 0, 1'b0, 1'b0, 16'h0);
    check("ch1_irq_clr", {31'h0, irq}, 32'h0);

    // write and out-of-range select
    cycle(16'h00A5, 1, 1'b1, 1'b0, 16'h1234);
    check("wr_ch1", {16'h0, pins_out}, 32'h3455);
    cycle(16'h00A5, 2, 1'b1, 1'b0, 16'hBEEF);
    check("wr_sel2", {16'h0, pins_out}, 32'h3455);
    peek(2, 16'h0000);
    cycle(16'h00A5, 0, 1'b1, 1'b1, 16'h0077);
    check("wr_rd_same", {16'h0, pins_out}, 32'h3477);

    // set-wins race on ch0
    for (int i = 0; i < 7; i++) cycle(16'h0011, 0, 1'b0, 1'b0, 16'h0);
    check("race_pre_irq", {31'h0, irq}, 32'h1);
    for (int i = 0; i < 5; i++) cycle(16'h005A, 0, 1'b0, 1'b0, 16'h0);
    cycle(16'h005A, 0, 1'b0, 1'b1, 16'h0);
    cycle(16'h005A, 0, 1'b0, 1'b0, 16'h0);
    check("race_irq1", {31'h0, irq}, 32'h1);
    cycle(16'h005A, 0, 1'b0, 1'b0, 16'h0);
    check("race_irq2", {31'h0, irq}, 32'h1);
    peek(0, 16'h005A);

    // reset mid-debounce discards the pending value
    for (int i = 0; i < 3; i++) cycle(16'h0099, 0, 1'b0, 1'b0, 16'h0);
    do_reset();
    cycle(16'h0099, 0, 1'b0, 1'b0, 16'h0);
    peek(0, 16'h0000);

    // write operations on ch0 (starts at 0x55 after reset)
`ifdef IO_PORT_BITOP_EN
    cycle(16'h0099, 0, 1'b1, 1'b0, 16'h40F0);
    check("bitop_set", {24'h0, pins_out[7:0]}, 32'hF5);
    cycle(16'h0099, 0, 1'b1, 1'b0, 16'h8005);
    check("bitop_clr", {24'h0, pins_out[7:0]}, 32'hF0);
    cycle(16'h0099, 0, 1'b1, 1'b0, 16'hC0FF);
    check("bitop_tgl", {24'h0, pins_out[7:0]}, 32'h0F);
`else
    cycle(16'h0099, 0, 1'b1, 1'b0, 16'h40F0);
    check("load_f0", {24'h0, pins_out[7:0]}, 32'hF0);
    cycle(16'h0099, 0, 1'b1, 1'b0, 16'hC0FF);
    check("load_ff", {24'h0, pins_out[7:0]}, 32'hFF);
`endif

    // randomized traffic
    for (int c = 0; c < CH; c++) begin hold_val[c] = 8'h99 * 8'(c == 0); hold_cnt[c] = 0; end
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold_cnt[c] == 0) begin
          hold_val[c] = 8'($urandom_range(0, 255));
          hold_cnt[c] = $urandom_range(1, 8);
        end
        hold_cnt[c]--;
      end
      p = {hold_val[1], hold_val[0]};
      if (i == 300) do_reset();
      cycle(p, SB'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), 16'($urandom()));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_port.md
Name: io_port

Overview:
- Parametrised successor to the fixed 8-bit IN/OUT path of the tiny16 top level.
- Provides CHANNELS independent WIDTH-bit input ports and output ports, addressed by a channel select and exchanged over the 16-bit system bus.
- Each input is synchronised, debounced and change-flagged, with an interrupt request when any flag is set. Output ports are latched from the bus under controller strobes.

Parameters:
- CHANNELS, 2, number of input and output channel pairs (1..8).
- SEL_BITS, 1, width of channel select; must be at least ceil(log2(CHANNELS)), with a minimum of 1.
- WIDTH, 8, bits per channel (1..16).
- DEBOUNCE, 4, cycles an input must stay stable before it is accepted (2..255).
- RESET_OUT, 8'h55, reset value loaded into every output latch, truncated or zero-extended to WIDTH.

Ports:
- clk  input  1  system clock (1 MHz domain).
- rst  input  1  asynchronous, active-high reset.
- sel  input  SEL_BITS  channel select for read and write.
- in_en  input  1  write strobe: latch bus data into output channel sel.
- in  input  16  bus data.
- out_en  input  1  read strobe: drive stable input of channel sel onto out.
- out  output  16  read data, zero-extended; all zeros when out_en=0.
- pins_in  input  CHANNELS*WIDTH  raw asynchronous inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- pins_out  output  CHANNELS*WIDTH  output latches, same packing as pins_in.
- irq  output  1  OR of all channel change flags.

Behaviour:
- Reset (async, rst=1):
  - sync1, sync2 and stable registers cleared to 0.
  - Debounce counters and change flags cleared to 0.
  - pins_out = RESET_OUT replicated per channel.
  - irq=0. out=0 while out_en=0.
- Reset asserted mid-debounce discards the pending value. After release, inputs need 2 sync cycles plus DEBOUNCE stable cycles before they are accepted.
- Input path, per channel, all bits of a channel treated as one word:
  - sync1 <= pins_in; sync2 <= sync1.
  - If sync2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE-1: stable <= sync2, cnt <= 0, flag <= 1.
  - Else: cnt <= cnt+1.
  - Any intervening return of sync2 to stable clears cnt (glitch rejection).
  - Counter width is ceil(log2(DEBOUNCE)); it never wraps.
- Latency: a clean step on a pin reaches stable exactly 2+DEBOUNCE clk edges after first sampling.
- Read:
  - out is combinational: out = {zero, stable[sel]} when out_en=1 and sel<CHANNELS; otherwise 0.
  - On the clk edge where out_en=1, flag[sel] is cleared.
  - If a new acceptance on the same channel coincides with the read, set wins: flag stays 1.
- Write: on the clk edge with in_en=1 and sel<CHANNELS, pins_out channel sel <= in[WIDTH-1:0]. Other channels hold their values.
- in_en and out_en asserted together are both honoured; the read returns the input side, which is unaffected by the write.
- sel >= CHANNELS: write ignored, read returns 0, no flag cleared.
- irq is registered: it is the OR of flags, updated one edge after a flag changes.

Optional Feature:
- IO_PORT_BITOP_EN, legal only when WIDTH <= 14. When defined, in[15:14] selects the write operation:
  - 00 = load
  - 01 = set (pins_out |= data)
  - 10 = clear (pins_out &= ~data)
  - 11 = toggle (pins_out ^= data)
- Data is in[WIDTH-1:0].
- When undefined, in[15:14] is ignored and every write is a load.

Test Plan:
- Reset check: rst pulse mid-run with CHANNELS=2, WIDTH=8 -> pins_out=16'h5555 immediately (async), irq=0, out=0.
- Clean input: pins_in ch0 0x00->0xA5 held steady -> stable visible at edge 2+4=6. On the next edge irq=1; out_en=1, sel=0 gives out=16'h00A5. irq returns to 0 one edge after the read clears the flag.
- Glitch rejection: ch1 pulse to 0x3C for 3 cycles (< DEBOUNCE) -> stable stays 0x00, irq stays 0. A 4-cycle-stable pulse is accepted.
- Write and range: in_en=1, sel=1, in=16'h1234 -> ch1 pins_out=0x34, ch0 unchanged at 0x55. A write with sel=2 and SEL_BITS=2 changes nothing; a read with sel=2 returns 0.
- Set-wins race: a read of ch0 on the same edge a new value is accepted on ch0 -> flag remains 1 and irq stays high.
- With IO_PORT_BITOP_EN: ch0=0x55; write 16'h40F0 -> 0xF5; write 16'h8005 -> 0xF0; write 16'hC0FF -> 0x0F.
